fetch_queue: RTL and testbench

- Instruction fetch stage plus prefetch buffer, directly upstream of decode.
- Issues word fetches to instruction memory over a req/gnt/rvalid interface and buffers the returned words in order.
- Presents one instruction per cycle through the IF/ID register (InstrD/PCD/ValidD). InstrD[23:0] feeds the immediate extender.
- Handles decode stall, decode flush, and branch redirect from Execute, including discarding in-flight fetches.

---
 rtl/fetch_queue.sv | 155 +++++++++++++++
 tb/tb_fetch_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage with an in-order prefetch buffer feeding the IF/ID register.
// In-flight fetches are counted so a redirect can discard responses from the abandoned stream.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        BranchTakenE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      pcf_q, pcf_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      qinstr_q [DEPTH];
    logic [31:0]      qinstr_d [DEPTH];
    logic [31:0]      qpc_q [DEPTH];
    logic [31:0]      qpc_d [DEPTH];
    logic [31:0]      instrd_q, instrd_d;
    logic [31:0]      pcd_q, pcd_d;
    logic             validd_q, validd_d;

    logic [31:0]      target_c;
    logic             room_c, grant_c, push_c, pop_c;

    // Buffered words plus in-flight fetches never exceed DEPTH, so a push always has a slot.
    assign target_c  = PCTargetE & 32'hFFFF_FFFC;
    assign room_c    = (SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(DEPTH);
    assign imem_req  = reset && room_c && !BranchTakenE;
    assign grant_c   = imem_req && imem_gnt;
    assign imem_addr = pcf_q;
    assign InstrD    = instrd_q;
    assign PCD       = pcd_q;
    assign ValidD    = validd_q;
    assign PCPlus8D  = pcd_q + 32'd8;

    always_comb begin
        pcf_d    = pcf_q;
        rsp_pc_d = rsp_pc_q;
        count_d  = count_q;
        outst_d  = outst_q + CNT_W'(grant_c) - CNT_W'(imem_rvalid);
        drop_d   = drop_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        qinstr_d = qinstr_q;
        qpc_d    = qpc_q;
        instrd_d = instrd_q;
        pcd_d    = pcd_q;
        validd_d = validd_q;
        push_c   = 1'b0;
        pop_c    = 1'b0;

        if (grant_c) begin
            pcf_d = pcf_q + 32'd4;
        end

        if (BranchTakenE) begin
            // Everything still in flight, including a response arriving now, is stale.
            pcf_d    = target_c;
            rsp_pc_d = target_c;
            drop_d   = outst_d;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            validd_d = 1'b0;
            instrd_d = '0;
        end else begin
            if (imem_rvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    push_c = 1'b1;
                end
            end

            if (FlushD) begin
                validd_d = 1'b0;
                instrd_d = '0;
            end else if (!StallD) begin
                if (count_q != '0) begin
                    pop_c    = 1'b1;
                    instrd_d = qinstr_q[rd_ptr_q];
                    pcd_d    = qpc_q[rd_ptr_q];
                    validd_d = 1'b1;
                end else begin
                    validd_d = 1'b0;
                end
            end

            if (push_c) begin
                qinstr_d[wr_ptr_q] = imem_rdata;
                qpc_d[wr_ptr_q]    = rsp_pc_q;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
                rsp_pc_d           = rsp_pc_q + 32'd4;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcf_q    <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            qinstr_q <= '{default: '0};
            qpc_q    <= '{default: '0};
            instrd_q <= '0;
            pcd_q    <= '0;
            validd_q <= 1'b0;
        end else begin
            pcf_q    <= pcf_d;
            rsp_pc_q <= rsp_pc_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            qinstr_q <= qinstr_d;
            qpc_q    <= qpc_d;
            instrd_q <= instrd_d;
            pcd_q    <= pcd_d;
            validd_q <= validd_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(push_c && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: a bench memory with variable latency, an epoch-tagged
// fetch model and a scoreboard of the instruction stream decode should see.
module tb_fetch_queue;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] dut_addr;
        logic [31:0] exp_addr;
        int unsigned epoch;
        longint      ready;
    } fetch_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        BranchTakenE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus8D;
    logic        ValidD;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .BranchTakenE(BranchTakenE), .PCTargetE(PCTargetE),
        .StallD(StallD), .FlushD(FlushD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
    );

    fetch_t      pending [$];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    longint      cyc = 0;
    int unsigned epoch = 0;
    logic [31:0] exp_addr = RST_PC;
    int          sb_elig = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rv_pct = 100;
    logic        req_s = 1'b0;
    logic [31:0] addr_s = '0;
    logic        br_p = 1'b0, fl_p = 1'b0, st_p = 1'b0, rst_p = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0, m_pc = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Bench memory and fetch model; responses are in order, at least one cycle after grant.
    initial begin : mem
        fetch_t p;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                pending.delete();
                sb.delete();
                sb_elig  = 0;
                exp_addr = RST_PC;
                epoch++;
            end else begin
                sb_elig = sb.size();
                if (req_s && imem_gnt) begin
                    p.dut_addr = addr_s;
                    p.exp_addr = exp_addr;
                    p.epoch    = epoch;
                    p.ready    = cyc + longint'($urandom_range(lat_max, lat_min));
                    pending.push_back(p);
                    exp_addr = exp_addr + 32'd4;
                end
                if (imem_rvalid && pending.size() > 0) begin
                    p = pending.pop_front();
                    if (!BranchTakenE && p.epoch == epoch)
                        sb.push_back('{pc: p.exp_addr, instr: word_of(p.exp_addr)});
                end
                if (BranchTakenE) begin
                    epoch++;
                    sb.delete();
                    sb_elig  = 0;
                    exp_addr = PCTargetE & 32'hFFFF_FFFC;
                end
            end
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (reset && pending.size() > 0) begin
                if (pending[0].ready <= cyc + 1 && $urandom_range(99) < rv_pct) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_of(pending[0].dut_addr);
                end
            end
        end
    end

    // Monitor: decode-side model updated from the controls seen at the edge just passed.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            m_valid = 1'b0;
            m_instr = '0;
            m_pc    = '0;
            chk("reset_imem_req", 32'(imem_req), 32'd0);
        end else if (rst_p) begin
            if (br_p || fl_p) begin
                m_valid = 1'b0;
                m_instr = '0;
            end else if (!st_p) begin
                chk("valid_vs_queue", 32'(ValidD), 32'(sb_elig > 0));
                if (ValidD) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_instr: PCD=%h InstrD=%h, expected none", PCD, InstrD);
                    end else begin
                        e = sb.pop_front();
                        m_valid = 1'b1;
                        m_instr = e.instr;
                        m_pc    = e.pc;
                    end
                end else begin
                    m_valid = 1'b0;
                end
            end
            chk("ValidD", 32'(ValidD), 32'(m_valid));
            chk("InstrD", InstrD, m_instr);
            chk("PCD", PCD, m_pc);
            chk("PCPlus8D", PCPlus8D, m_pc + 32'd8);
            chk("imem_addr", imem_addr, exp_addr);
            chk("imem_req", 32'(imem_req),
                32'(!BranchTakenE && (sb.size() + pending.size() < int'(DEPTH))));
        end
        req_s  = imem_req;
        addr_s = imem_addr;
        br_p   = BranchTakenE;
        fl_p   = FlushD;
        st_p   = StallD;
        rst_p  = reset;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ValidD"}, 32'(ValidD), 32'd0);
        chk({tag, "_InstrD"}, InstrD, 32'd0);
        chk({tag, "_PCD"}, PCD, 32'd0);
        chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, RST_PC);
    endtask

    task automatic next_valid(input string nm, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ValidD) seen = 1'b1;
        end
        if (seen) chk(nm, PCD, exp_pc);
        else begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no ValidD within 60 cycles, expected PCD %h", nm, exp_pc);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        imem_gnt = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        BranchTakenE = 1'b0;
        rv_pct = 100;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (pending.size() == 0 && sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d fetches and %0d words left, expected 0", pending.size(), sb.size());
        end
    endtask

    initial begin : stim
        int cnt;
        bit ok;
        reset = 1'b0;
        imem_gnt = 1'b0;
        BranchTakenE = 1'b0;
        PCTargetE = '0;
        StallD = 1'b0;
        FlushD = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("por");
        reset = 1'b1;

        // Free run from a reset PC just below the 32-bit wrap point.
        imem_gnt = 1'b1;
        next_valid("wrap_pc0", 32'hFFFF_FFF8);
        next_valid("wrap_pc1", 32'hFFFF_FFFC);
        next_valid("wrap_pc2", 32'h0000_0000);
        repeat (5) @(negedge clk);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ValidD) cnt++;
        end
        chk("free_run_rate", 32'(cnt), 32'd20);

        // Backpressure with slow memory.
        step();
        lat_min = 3;
        lat_max = 3;
        repeat (5) step();
        StallD = 1'b1;
        repeat (10) step();
        StallD = 1'b0;
        repeat (20) step();

        // Redirect with two fetches in flight.
        drain();
        lat_min = 3;
        lat_max = 3;
        imem_gnt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (pending.size() == 2) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL redir_setup: %0d in flight, expected 2", pending.size());
        end
        BranchTakenE = 1'b1;
        PCTargetE = 32'h0000_0103;
        step();
        BranchTakenE = 1'b0;
        @(negedge clk);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_bubble", 32'(ValidD), 32'd0);
        next_valid("redir_first_pc", 32'h0000_0100);

        // Redirect, flush, stall and a response all at one edge.
        step();
        lat_min = 1;
        lat_max = 3;
        StallD = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            if (imem_rvalid && sb.size() > 0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL simul_setup: no response with queued words, expected one");
        end
        BranchTakenE = 1'b1;
        FlushD = 1'b1;
        PCTargetE = 32'h0000_2002;
        step();
        BranchTakenE = 1'b0;
        FlushD = 1'b0;
        StallD = 1'b0;
        @(negedge clk);
        chk("simul_bubble", 32'(ValidD), 32'd0);
        chk("simul_addr", imem_addr, 32'h0000_2000);
        next_valid("simul_first_pc", 32'h0000_2000);

        // Randomised traffic.
        step();
        lat_min = 1;
        lat_max = 4;
        rv_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            imem_gnt     = ($urandom_range(99) < 70);
            StallD       = ($urandom_range(99) < 20);
            FlushD       = ($urandom_range(99) < 8);
            BranchTakenE = ($urandom_range(99) < 4);
            PCTargetE    = $urandom;
            step();
        end

        // Mid-run reset with three words queued and one fetch in flight.
        drain();
        lat_min = 3;
        lat_max = 3;
        StallD = 1'b1;
        imem_gnt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (sb.size() == 3 && pending.size() == 1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL midrst_setup: %0d queued, %0d in flight, expected 3 and 1", sb.size(), pending.size());
        end
        #1 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) step();
        StallD = 1'b0;
        reset = 1'b1;
        next_valid("midrst_first_pc", RST_PC);
        next_valid("midrst_second_pc", RST_PC + 32'd4);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
